// File: rtl/aes_decrypt_top.sv
// AES-128 iterative inverse cipher: forward key expansion up to rk10, then one
// decryption round per clock while the round key is walked back to rk0.

module aes_sbox #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int unsigned i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  if (INVERSE) begin : g_inv
    logic [7:0] pre;
    always_comb begin
      pre  = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
      dout = gf_inv(pre);
    end
  end else begin : g_fwd
    logic [7:0] inv;
    always_comb begin
      inv  = gf_inv(din);
      dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  end

endmodule

module aes_decrypt_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         en_q, en_d;
  logic         valid_q, valid_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] dout_q, dout_d;

  logic [127:0] shifted, subbed, added, mixed;
  logic [127:0] rk_fwd, rk_inv;
  logic [31:0]  key_word, key_rot, key_sub, key_temp;
  logic         start;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2    = xt(s[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte 4c+r sits in column c, row r; InvShiftRows rotates row r right by r.
  always_comb begin
    shifted = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    aes_sbox #(.INVERSE(1'b1)) u_inv_sbox (
      .din  (shifted[127-8*g -: 8]),
      .dout (subbed[127-8*g -: 8])
    );
  end

  always_comb begin
    added = subbed ^ rk_q;
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(added[127-32*c -: 32]);
    end
  end

  // One S-box word serves both directions: forward uses w3 of rk_n, inverse
  // recovers w3 of rk_(n-1) as w3^w2 of rk_n.
  always_comb begin
    key_word = (fsm_q == KEYEXP) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
    key_rot  = {key_word[23:0], key_word[31:24]};
  end

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox #(.INVERSE(1'b0)) u_key_sbox (
      .din  (key_rot[31-8*g -: 8]),
      .dout (key_sub[31-8*g -: 8])
    );
  end

  always_comb begin
    key_temp      = key_sub ^ {rcon(rnd_q), 24'h0};
    rk_fwd[127:96] = rk_q[127:96] ^ key_temp;
    rk_fwd[95:64]  = rk_q[95:64] ^ rk_fwd[127:96];
    rk_fwd[63:32]  = rk_q[63:32] ^ rk_fwd[95:64];
    rk_fwd[31:0]   = rk_q[31:0] ^ rk_fwd[63:32];
    rk_inv = {rk_q[127:96] ^ key_temp,
              rk_q[95:64] ^ rk_q[127:96],
              rk_q[63:32] ^ rk_q[95:64],
              rk_q[31:0] ^ rk_q[63:32]};
  end

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    en_d    = AES_en;
    valid_d = 1'b0;
    state_d = state_q;
    rk_d    = rk_q;
    dout_d  = dout_q;
    start   = AES_en & ~en_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = AES_data_in;
          rk_d    = AES_key_in;
          rnd_d   = 4'd1;
          fsm_d   = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_d = rk_fwd;
        if (rnd_q == 4'd10) fsm_d = INIT;
        else                rnd_d = rnd_q + 4'd1;
      end
      INIT: begin
        state_d = state_q ^ rk_q;
        rk_d    = rk_inv;
        rnd_d   = 4'd9;
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = mixed;
        rk_d    = rk_inv;
        if (rnd_q == 4'd1) fsm_d = FINAL;
        else               rnd_d = rnd_q - 4'd1;
      end
      FINAL: begin
        dout_d  = added;
        valid_d = 1'b1;
        rnd_d   = 4'd0;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      state_q <= '0;
      rk_q    <= '0;
      dout_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    AES_data_out       = dout_q;
    AES_data_out_valid = valid_q;
  end

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Scoreboard bench for aes_decrypt_top: expectations queued at start, DUT
// results captured by a monitor and compared inside each scenario task.
module tb_aes_decrypt_top;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;

  typedef struct packed {
    logic [127:0] data;
    logic [31:0]  cyc;
  } entry_t;

  entry_t      exp_q[$];
  entry_t      res_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] cyc = '0;

  aes_decrypt_top dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
  );

  always #5 AES_clk = ~AES_clk;
  always @(posedge AES_clk) cyc <= cyc + 32'd1;
  always @(negedge AES_clk) if (AES_data_out_valid === 1'b1) res_q.push_back({AES_data_out, cyc});

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge AES_clk);
      #1;
    end
  endtask

  // Raise AES_en for one cycle; the next rising clock edge is the start edge.
  task automatic start_block(input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] pt, input bit push);
    AES_data_in = ct;
    AES_key_in  = key;
    AES_en      = 1'b1;
    if (push) exp_q.push_back({pt, cyc + 32'd1});
    tick();
    AES_en = 1'b0;
  endtask

  task automatic wait_results(input int unsigned n, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && res_q.size() < n; i++) tick();
    ok = (res_q.size() >= n);
  endtask

  task automatic flush();
    exp_q.delete();
    res_q.delete();
  endtask

  task automatic test_reset();
    AES_rst_n = 1'b0; AES_en = 1'b0; AES_data_in = '0; AES_key_in = '0;
    #1;
    checks++; if (AES_data_out !== 128'h0) begin errors++; $display("FAIL reset_data: got %h required 0", AES_data_out); end
    checks++; if (AES_data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", AES_data_out_valid); end
    tick(3);
    AES_rst_n = 1'b1;
    tick(30);
    checks++; if (res_q.size() != 0) begin errors++; $display("FAIL reset_idle: valid pulses %0d required 0", res_q.size()); end
    flush();
  endtask

  task automatic test_vector1();
    entry_t r, e; bit ok;
    flush();
    start_block(CT1, K1, PT1, 1'b1);
    wait_results(1, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL v1_timeout: results %0d required 1", res_q.size()); end
    else begin
      r = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.data !== e.data) begin errors++; $display("FAIL v1_data: got %h required %h", r.data, e.data); end
      checks++; if (r.cyc - e.cyc !== 32'd21) begin errors++; $display("FAIL v1_latency: got %0d required 21", r.cyc - e.cyc); end
      tick();
      checks++; if (AES_data_out_valid !== 1'b0) begin errors++; $display("FAIL v1_pulse_width: valid %b required 0", AES_data_out_valid); end
      checks++; if (AES_data_out !== PT1) begin errors++; $display("FAIL v1_hold: got %h required %h", AES_data_out, PT1); end
    end
  endtask

  task automatic test_vector2();
    entry_t r, e; bit ok;
    flush();
    start_block(CT2, K2, PT2, 1'b1);
    tick(10);
    checks++; if (AES_data_out !== PT1) begin errors++; $display("FAIL v2_midop_hold: got %h required %h", AES_data_out, PT1); end
    wait_results(1, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL v2_timeout: results %0d required 1", res_q.size()); end
    else begin
      r = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.data !== e.data) begin errors++; $display("FAIL v2_data: got %h required %h", r.data, e.data); end
      checks++; if (r.cyc - e.cyc !== 32'd21) begin errors++; $display("FAIL v2_latency: got %0d required 21", r.cyc - e.cyc); end
    end
  endtask

  task automatic test_held_high();
    entry_t r, e;
    flush();
    AES_data_in = CT1; AES_key_in = K1; AES_en = 1'b1;
    exp_q.push_back({PT1, cyc + 32'd1});
    for (int unsigned i = 1; i <= 51; i++) begin
      tick();
      if (i >= 5 && i <= 7) begin
        AES_data_in = {$urandom, $urandom, $urandom, $urandom};
        AES_key_in  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    AES_en = 1'b0;
    tick(30);
    checks++;
    if (res_q.size() != 1) begin errors++; $display("FAIL held_count: valid pulses %0d required 1", res_q.size()); end
    else begin
      r = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.data !== e.data) begin errors++; $display("FAIL held_data: got %h required %h", r.data, e.data); end
      checks++; if (r.cyc - e.cyc !== 32'd21) begin errors++; $display("FAIL held_latency: got %0d required 21", r.cyc - e.cyc); end
    end
  endtask

  task automatic test_reset_mid();
    entry_t r, e; bit ok;
    flush();
    start_block(CT2, K2, PT2, 1'b0);
    tick(13);
    AES_rst_n = 1'b0;
    #1;
    checks++; if (AES_data_out !== 128'h0) begin errors++; $display("FAIL midrst_data: got %h required 0", AES_data_out); end
    checks++; if (AES_data_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", AES_data_out_valid); end
    tick();
    AES_rst_n = 1'b1;
    tick(30);
    checks++; if (res_q.size() != 0) begin errors++; $display("FAIL midrst_abort: valid pulses %0d required 0", res_q.size()); end
    flush();
    start_block(CT1, K1, PT1, 1'b1);
    wait_results(1, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: results %0d required 1", res_q.size()); end
    else begin
      r = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.data !== e.data) begin errors++; $display("FAIL midrst_data_after: got %h required %h", r.data, e.data); end
      checks++; if (r.cyc - e.cyc !== 32'd21) begin errors++; $display("FAIL midrst_latency: got %0d required 21", r.cyc - e.cyc); end
    end
  endtask

  task automatic test_back_to_back();
    entry_t r1, r2, e1, e2; bit ok; bit seen;
    flush();
    start_block(CT1, K1, PT1, 1'b1);
    seen = 1'b0;
    for (int unsigned i = 0; i < 40 && !seen; i++) begin
      if (AES_data_out_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_first_timeout: valid %b required 1", AES_data_out_valid); end
    start_block(CT2, K2, PT2, 1'b1);
    wait_results(2, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: results %0d required 2", res_q.size()); end
    else begin
      r1 = res_q.pop_front(); r2 = res_q.pop_front();
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks++; if (r1.data !== e1.data) begin errors++; $display("FAIL b2b_data1: got %h required %h", r1.data, e1.data); end
      checks++; if (r2.data !== e2.data) begin errors++; $display("FAIL b2b_data2: got %h required %h", r2.data, e2.data); end
      checks++; if (r1.cyc - e1.cyc !== 32'd21) begin errors++; $display("FAIL b2b_latency1: got %0d required 21", r1.cyc - e1.cyc); end
      checks++; if (r2.cyc - r1.cyc !== 32'd22) begin errors++; $display("FAIL b2b_spacing: got %0d required 22", r2.cyc - r1.cyc); end
    end
  endtask

  task automatic test_busy_en();
    entry_t r, e;
    flush();
    start_block(CT2, K2, PT2, 1'b1);
    tick(8);
    start_block(CT1, K1, PT1, 1'b0);
    tick(40);
    checks++;
    if (res_q.size() != 1) begin errors++; $display("FAIL busy_count: valid pulses %0d required 1", res_q.size()); end
    else begin
      r = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.data !== e.data) begin errors++; $display("FAIL busy_data: got %h required %h", r.data, e.data); end
      checks++; if (r.cyc - e.cyc !== 32'd21) begin errors++; $display("FAIL busy_latency: got %0d required 21", r.cyc - e.cyc); end
    end
  endtask

  task automatic test_en_at_release();
    entry_t r, e;
    flush();
    AES_rst_n = 1'b0;
    AES_data_in = CT2; AES_key_in = K2; AES_en = 1'b1;
    tick(2);
    AES_rst_n = 1'b1;
    exp_q.push_back({PT2, cyc + 32'd1});
    tick(3);
    AES_en = 1'b0;
    tick(50);
    checks++;
    if (res_q.size() != 1) begin errors++; $display("FAIL release_count: valid pulses %0d required 1", res_q.size()); end
    else begin
      r = res_q.pop_front(); e = exp_q.pop_front();
      checks++; if (r.data !== e.data) begin errors++; $display("FAIL release_data: got %h required %h", r.data, e.data); end
      checks++; if (r.cyc - e.cyc !== 32'd21) begin errors++; $display("FAIL release_latency: got %0d required 21", r.cyc - e.cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_vector1();
    test_vector2();
    test_held_high();
    test_reset_mid();
    test_back_to_back();
    test_busy_en();
    test_en_at_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_decrypt_top.md
AES_DECRYPT_TOP -- requirements
Module: aes_decrypt_top

Interface
REQ-001 SHALL have AES_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have AES_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have AES_en  input  1  start request; rising edge starts one decryption.
REQ-004 SHALL have AES_data_in  input  128  ciphertext block; bit 127 = byte 0 MSB (FIPS-197 order).
REQ-005 SHALL have AES_key_in  input  128  AES-128 cipher key, same byte order.
REQ-006 SHALL have AES_data_out  output  128  recovered plaintext.
REQ-007 SHALL have AES_data_out_valid  output  1  one-cycle pulse marking new AES_data_out.

Function
REQ-008 SHALL implement the AES-128 inverse cipher per FIPS-197 section 5.3, iterative, one round per cycle.
REQ-009 SHALL register AES_en each cycle; a start is AES_en=1 with previous sample 0, accepted only in IDLE; a held-high AES_en never retriggers.
REQ-010 SHALL capture AES_data_in and AES_key_in on the start edge (edge 0); input changes afterwards are ignored until return to IDLE.
REQ-011 FSM states SHALL be IDLE, KEYEXP, INIT, ROUND, FINAL; no other states.
REQ-012 IDLE->KEYEXP on start; KEYEXP runs 10 cycles (edges 1-10) of forward key expansion, holding only the current round key, ending with rk10.
REQ-013 KEYEXP->INIT; at edge 11 state = ciphertext XOR rk10, round key steps back to rk9 via inverse key schedule.
REQ-014 INIT->ROUND; edges 12-20 (9 cycles) each apply InvShiftRows, InvSubBytes, AddRoundKey(rk_n), InvMixColumns; round key steps back one per cycle.
REQ-015 ROUND->FINAL; edge 21 applies InvShiftRows, InvSubBytes, AddRoundKey(rk0), loads AES_data_out, asserts AES_data_out_valid; FSM -> IDLE.
REQ-016 Latency from start edge to valid edge SHALL be exactly 21 cycles; throughput 1 block per 22 cycles minimum.
REQ-017 AES_data_out_valid SHALL be high for exactly one cycle per completed block.
REQ-018 AES_data_out SHALL hold its value until the next completion; never changes mid-operation.
REQ-019 Inverse key schedule SHALL derive rk_{n-1} from rk_n combinationally (w[i-4] = w[i] XOR f(w[i-1])) using 4 forward S-box lookups and Rcon indexed by a 4-bit round counter.
REQ-020 Round counter SHALL count 1-10 in KEYEXP and 9 down to 1 in ROUND; no wrap beyond these ranges.
REQ-021 InvSubBytes SHALL use 16 instances of the shared inverse S-box table module; InvMixColumns SHALL use GF(2^8) multiply by 0e/0b/0d/09, modulo x^8+x^4+x^3+x+1.
REQ-022 A rising AES_en while not IDLE SHALL be dropped, with no queuing; the edge detector still updates.
REQ-023 A start in the cycle after valid SHALL be accepted normally.

Reset
REQ-024 AES_rst_n=0 SHALL immediately force IDLE, round counter 0, state/key registers 0, AES_data_out=128'h0, AES_data_out_valid=0, registered AES_en=0.
REQ-025 Reset asserted mid-operation SHALL abort the block with no valid pulse; after release a new rising AES_en is required.
REQ-026 If AES_en is already high when reset releases, it SHALL count as a rising edge, giving one start.

Verification
REQ-027 Key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, AES_en pulse -> 21 cycles later out 00112233445566778899aabbccddeeff, valid 1 cycle.
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734.
REQ-029 AES_en held high 51 cycles, data_in changed at cycles 5/6/7 -> exactly one valid pulse, result matches the data captured at start.
REQ-030 Reset pulsed at cycle 15 of an operation -> outputs 0, no valid; next rising AES_en completes correctly.
REQ-031 Back-to-back: second rising AES_en one cycle after the valid edge -> second valid 22 cycles after the first, both correct.
REQ-032 Rising AES_en at cycle 10 of an operation -> ignored, one valid only, result unchanged.
